// File: rtl/conv_tap_mult_pipe_pkg.sv
// Shared constants and width helpers for the convolution tap-multiply stage.
package conv_tap_mult_pipe_pkg;

  localparam int TAPS_DEF   = 9;
  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int LAT_DEF    = 2;

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  // A single-tap kernel still needs a 1-bit index port.
  function automatic int idx_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/conv_tap_mult_pipe_if.sv
// Stream and coefficient-bank signals between window-gather, this stage and the adder tree.
interface conv_tap_mult_pipe_if
  import conv_tap_mult_pipe_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
);
  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int IDX_W  = idx_w(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*DATA_W-1:0]   pix_in;
  logic                     signed_mode;
  logic                     coef_wr_en;
  logic [IDX_W-1:0]         coef_wr_idx;
  logic [COEF_W-1:0]        coef_wr_data;
  logic                     coef_swap;
  logic                     out_valid;
  logic                     out_ready;
  logic [TAPS*PROD_W-1:0]   prod_out;
  logic [TAPS*COEF_W-1:0]   coef_out;

  modport master (
    output in_valid, pix_in, signed_mode, coef_wr_en, coef_wr_idx, coef_wr_data,
           coef_swap, out_ready,
    input  in_ready, out_valid, prod_out, coef_out
  );

  modport slave (
    input  in_valid, pix_in, signed_mode, coef_wr_en, coef_wr_idx, coef_wr_data,
           coef_swap, out_ready,
    output in_ready, out_valid, prod_out, coef_out
  );

endinterface

// File: rtl/conv_tap_mult_pipe_tap.sv
// One tap: multiply at acceptance, then carry product and coefficient through LAT stages.
module conv_tap_mult_pipe_tap
  import conv_tap_mult_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int LAT    = LAT_DEF,
  localparam int PROD_W = prod_w(DATA_W, COEF_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] pix_i,
  input  logic [COEF_W-1:0] coef_i,
  output logic [PROD_W-1:0] prod_o,
  output logic [COEF_W-1:0] coef_o
);

  logic [PROD_W-1:0]            pix_ext_s;
  logic [PROD_W-1:0]            coef_ext_s;
  logic [PROD_W-1:0]            mult_s;
  logic [LAT-1:0][PROD_W-1:0]   prod_q, prod_d;
  logic [LAT-1:0][COEF_W-1:0]   coef_q, coef_d;

  // Extending both operands to PROD_W makes the truncated product exact for either mode.
  always_comb begin
    pix_ext_s  = {{COEF_W{signed_mode & pix_i[DATA_W-1]}}, pix_i};
    coef_ext_s = {{DATA_W{signed_mode & coef_i[COEF_W-1]}}, coef_i};
    mult_s     = pix_ext_s * coef_ext_s;
  end

  always_comb begin
    prod_d = prod_q;
    coef_d = coef_q;
    if (adv) begin
      prod_d[0] = mult_s;
      coef_d[0] = coef_i;
      for (int s = 1; s < LAT; s++) begin
        prod_d[s] = prod_q[s-1];
        coef_d[s] = coef_q[s-1];
      end
    end else begin
      prod_d = prod_q;
      coef_d = coef_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      coef_q <= '0;
    end else begin
      prod_q <= prod_d;
      coef_q <= coef_d;
    end
  end

  assign prod_o = prod_q[LAT-1];
  assign coef_o = coef_q[LAT-1];

endmodule

// File: rtl/conv_tap_mult_pipe.sv
// Per-tap multiply stage: double-buffered coefficient bank, valid chain and stall control.
module conv_tap_mult_pipe
  import conv_tap_mult_pipe_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  conv_tap_mult_pipe_if.slave bus
);

  localparam int PROD_W = prod_w(DATA_W, COEF_W);

  logic                          adv_s;
  logic                          accept_s;
  logic [LAT-1:0]                valid_q, valid_d;
  logic [TAPS-1:0][COEF_W-1:0]   shadow_q, shadow_d;
  logic [TAPS-1:0][COEF_W-1:0]   active_q, active_d;
  logic [TAPS-1:0][PROD_W-1:0]   prod_s;
  logic [TAPS-1:0][COEF_W-1:0]   coef_s;

  assign adv_s         = ~valid_q[LAT-1] | bus.out_ready;
  assign accept_s      = bus.in_valid & adv_s & ~rst;
  assign bus.in_ready  = adv_s & ~rst;
  assign bus.out_valid = valid_q[LAT-1];
  assign bus.prod_out  = prod_s;
  assign bus.coef_out  = coef_s;

  // A swap commits shadow_d, so a write in the same cycle is part of the new bank.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.coef_wr_en && (32'(bus.coef_wr_idx) < TAPS)) begin
      shadow_d[bus.coef_wr_idx] = bus.coef_wr_data;
    end else begin
      shadow_d = shadow_q;
    end
    if (bus.coef_swap) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (adv_s) begin
      valid_d[0] = accept_s;
      for (int s = 1; s < LAT; s++) begin
        valid_d[s] = valid_q[s-1];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      valid_q  <= valid_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Each tap reads active_q before this edge's swap lands, so an accepted sample keeps the old bank.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    conv_tap_mult_pipe_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .LAT    (LAT)
    ) u_tap (
      .clk         (clk),
      .rst         (rst),
      .adv         (adv_s),
      .signed_mode (bus.signed_mode),
      .pix_i       (bus.pix_in[i*DATA_W +: DATA_W]),
      .coef_i      (active_q[i]),
      .prod_o      (prod_s[i]),
      .coef_o      (coef_s[i])
    );
  end

endmodule

// File: tb/tb_conv_tap_mult_pipe.sv
// Directed bench for conv_tap_mult_pipe with a queue-based reference model.
module tb_conv_tap_mult_pipe;

  localparam int TAPS   = 9;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int LAT    = 2;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = 4;

  typedef struct {
    logic [TAPS*PROD_W-1:0] prod;
    logic [TAPS*COEF_W-1:0] coef;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   delivered = 0;
  exp_t exp_q[$];
  logic [COEF_W-1:0] m_shadow [TAPS];
  logic [COEF_W-1:0] m_active [TAPS];
  logic [TAPS*DATA_W-1:0] base_pix;

  conv_tap_mult_pipe_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

  conv_tap_mult_pipe #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed operands are reinterpreted as negative integers, multiplied, then wrapped to PROD_W.
  function automatic logic [PROD_W-1:0] mul_ref(input logic [DATA_W-1:0] p,
                                               input logic [COEF_W-1:0] c, input logic sm);
    longint a, b;
    a = longint'(p);
    b = longint'(c);
    if (sm && p[DATA_W-1]) a = a - (longint'(1) << DATA_W);
    if (sm && c[COEF_W-1]) b = b - (longint'(1) << COEF_W);
    return PROD_W'(a * b);
  endfunction

  // Reference model: sampled mid-cycle, it predicts what the coming edge does.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < TAPS; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 expected no pending sample");
        end else begin
          chk("stream_prod", bus.prod_out, exp_q[0].prod);
          chk("stream_coef", bus.coef_out, exp_q[0].coef);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < TAPS; i++) begin
          e.prod[i*PROD_W +: PROD_W] = mul_ref(bus.pix_in[i*DATA_W +: DATA_W], m_active[i], bus.signed_mode);
          e.coef[i*COEF_W +: COEF_W] = m_active[i];
        end
        exp_q.push_back(e);
      end
      if (bus.coef_wr_en && int'(bus.coef_wr_idx) < TAPS) m_shadow[bus.coef_wr_idx] = bus.coef_wr_data;
      if (bus.coef_swap) begin
        for (int i = 0; i < TAPS; i++) m_active[i] = m_shadow[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [IDX_W-1:0] idx, input logic [COEF_W-1:0] d, input logic swap);
    bus.coef_wr_en = 1'b1; bus.coef_wr_idx = idx; bus.coef_wr_data = d; bus.coef_swap = swap;
    tick();
    bus.coef_wr_en = 1'b0; bus.coef_swap = 1'b0;
  endtask

  task automatic do_swap();
    bus.coef_swap = 1'b1;
    tick();
    bus.coef_swap = 1'b0;
  endtask

  // Single sample into an empty pipe; returns tap-0 outputs when the sample reaches the output.
  task automatic send_one(input logic [DATA_W-1:0] p0, input logic sm, input logic swap,
                          output logic [PROD_W-1:0] prod0, output logic [COEF_W-1:0] coef0);
    logic [TAPS*DATA_W-1:0] pix;
    pix = base_pix;
    pix[DATA_W-1:0] = p0;
    chk("idle_in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.pix_in = pix; bus.signed_mode = sm; bus.coef_swap = swap;
    tick();
    bus.in_valid = 1'b0; bus.coef_swap = 1'b0;
    chk("lat_not_early", bus.out_valid, 1'b0);
    repeat (LAT-1) tick();
    chk("lat_exact", bus.out_valid, 1'b1);
    prod0 = bus.prod_out[PROD_W-1:0];
    coef0 = bus.coef_out[COEF_W-1:0];
  endtask

  task automatic send(input logic [TAPS*DATA_W-1:0] pix, input logic sm);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.in_valid = 1'b1; bus.pix_in = pix; bus.signed_mode = sm;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      n++;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no in_ready expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [PROD_W-1:0] p;
    logic [COEF_W-1:0] c;
    logic [TAPS*COEF_W-1:0] eb;
    int d0;

    bus.in_valid = 1'b0; bus.pix_in = '0; bus.signed_mode = 1'b0;
    bus.coef_wr_en = 1'b0; bus.coef_wr_idx = '0; bus.coef_wr_data = '0;
    bus.coef_swap = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) base_pix[i*DATA_W +: DATA_W] = DATA_W'(i*17 + 5);

    chk("model_pin_unsigned", mul_ref(8'd255, 8'd3, 1'b0), 16'h02FD);
    chk("model_pin_signed", mul_ref(8'h05, 8'hFE, 1'b1), 16'hFFF6);
    chk("model_pin_signed_neg_neg", mul_ref(8'h80, 8'h80, 1'b1), 16'h4000);

    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_prod_out", bus.prod_out, '0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("release_in_ready", bus.in_ready, 1'b1);

    // Unsigned: all coefficients 3.
    for (int i = 0; i < TAPS; i++) wr_coef(IDX_W'(i), 8'd3, 1'b0);
    do_swap();
    send_one(8'd255, 1'b0, 1'b0, p, c);
    chk("unsigned_prod", p, 16'h02FD);
    chk("unsigned_coef", c, 8'h03);
    tick();

    // Signed versus unsigned on the same operands.
    wr_coef('0, 8'hFE, 1'b1);
    send_one(8'h05, 1'b1, 1'b0, p, c);
    chk("signed_prod", p, 16'hFFF6);
    tick();
    send_one(8'h05, 1'b0, 1'b0, p, c);
    chk("unsigned_same_ops", p, 16'h04F6);
    tick();

    // Swap coincident with acceptance of A: A keeps the old bank.
    wr_coef('0, 8'd1, 1'b1);
    wr_coef('0, 8'd7, 1'b0);
    send_one(8'd10, 1'b0, 1'b1, p, c);
    chk("swap_a_coef", c, 8'd1);
    chk("swap_a_prod", p, 16'h000A);
    tick();
    send_one(8'd10, 1'b0, 1'b0, p, c);
    chk("swap_b_coef", c, 8'd7);
    chk("swap_b_prod", p, 16'h0046);
    tick();

    // Write and swap together, then an out-of-range write.
    wr_coef('0, 8'd9, 1'b1);
    send_one(8'd2, 1'b0, 1'b0, p, c);
    chk("wrswap_coef", c, 8'd9);
    chk("wrswap_prod", p, 16'h0012);
    tick();
    wr_coef(IDX_W'(TAPS), 8'hAA, 1'b1);
    send_one(8'd2, 1'b0, 1'b0, p, c);
    for (int i = 0; i < TAPS; i++) eb[i*COEF_W +: COEF_W] = 8'd3;
    eb[COEF_W-1:0] = 8'd9;
    chk("oob_idx_bank", bus.coef_out, eb);
    tick();

    // Backpressure: six samples, out_ready low for three cycles mid-stream.
    d0 = delivered;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          logic [TAPS*DATA_W-1:0] px;
          for (int i = 0; i < TAPS; i++) px[i*DATA_W +: DATA_W] = DATA_W'(k*31 + i*7 + 200);
          send(px, k[0]);
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) tick();
        bus.out_ready = 1'b0;
        #1;
        chk("stall_in_ready", bus.in_ready, 1'b0);
        chk("stall_out_valid", bus.out_valid, 1'b1);
        repeat (3) tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", delivered - d0, 6);

    // Reset with samples in flight.
    bus.in_valid = 1'b1; bus.pix_in = base_pix; bus.signed_mode = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_prod_out", bus.prod_out, '0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    chk("midrst_coef_out", bus.coef_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", bus.in_ready, 1'b1);
    repeat (5) tick();
    send_one(8'd255, 1'b0, 1'b0, p, c);
    chk("post_rst_bank_prod", p, 16'h0000);
    chk("post_rst_bank_coef", c, 8'h00);
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
